// File: rtl/pulse_to_level_pkg.sv
// Shared encodings for the pulse-to-level converter.
package pulse_to_level_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_RETRIG = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_LATCH  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/pulse_to_level_rise_detect.sv
// Rising-edge detector; history resets high so a level held across reset is not an event.
module pulse_to_level_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic p,
    output logic ev
);

    logic p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= 1'b1;
        else        p_q <= p;
    end

    assign ev = p & ~p_q;

endmodule

// File: rtl/pulse_to_level.sv
// Pulse-to-level converter: hold, retriggerable hold, toggle and latch modes.
module pulse_to_level
    import pulse_to_level_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       P,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       L,
    output logic       done
);

    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic          ev;
    logic [1:0]    mode_q;
    state_t        state;
    logic [CW-1:0] cnt;

    pulse_to_level_rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .p     (P),
        .ev    (ev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= MODE_HOLD;
            done   <= 1'b0;
        end else begin
            mode_q <= mode;
            done   <= 1'b0;
            if (clr) begin
                state <= ST_IDLE;
                cnt   <= '0;
                done  <= (state == ST_ACTIVE);
            end else if (mode != mode_q && state == ST_ACTIVE) begin
                // switching modes mid-level aborts; the event on this edge is dropped
                state <= ST_IDLE;
                cnt   <= '0;
                done  <= 1'b1;
            end else begin
                case (mode_t'(mode))
                    MODE_HOLD, MODE_RETRIG: begin
                        if (state == ST_IDLE) begin
                            if (ev) begin
                                state <= ST_ACTIVE;
                                cnt   <= RELOAD;
                            end
                        end else if (ev && mode == MODE_RETRIG) begin
                            cnt <= RELOAD;
                        end else if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    MODE_TOGGLE: begin
                        cnt <= '0;
                        if (ev) begin
                            state <= (state == ST_ACTIVE) ? ST_IDLE : ST_ACTIVE;
                            done  <= (state == ST_ACTIVE);
                        end
                    end
                    MODE_LATCH: begin
                        cnt <= '0;
                        if (ev) state <= ST_ACTIVE;
                    end
                endcase
            end
        end
    end

    assign L = (state == ST_ACTIVE);

endmodule

// File: tb/tb_pulse_to_level.sv
// Randomized and directed bench for pulse_to_level at HOLD_CYCLES 8 and 1 against an event-time model.
module tb_pulse_to_level;
    import pulse_to_level_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       P = 1'b1;
    logic [1:0] mode = MODE_HOLD;
    logic       clr = 1'b0;
    logic       L8, d8, L1, d1;

    int total = 0;
    int bad   = 0;

    // model: level plus the absolute edge number at which a one-shot expires
    int  t = 0;
    bit  m_pprev = 1'b1;
    bit  [1:0] m_mprev = 2'b00;
    bit  lvl [2];
    bit  dex [2];
    int  expt [2];
    int  hc [2] = '{8, 1};

    always #5 clk = ~clk;

    pulse_to_level #(.HOLD_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .P(P), .mode(mode), .clr(clr), .L(L8), .done(d8)
    );
    pulse_to_level #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .P(P), .mode(mode), .clr(clr), .L(L1), .done(d1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pprev = 1'b1;
        m_mprev = 2'b00;
        for (int i = 0; i < 2; i++) begin
            lvl[i] = 1'b0;
            dex[i] = 1'b0;
            expt[i] = 0;
        end
    endtask

    task automatic model_edge(input bit p, input bit [1:0] m, input bit c);
        bit ev;
        ev = p & ~m_pprev;
        t++;
        for (int i = 0; i < 2; i++) begin
            dex[i] = 1'b0;
            if (c) begin
                dex[i] = lvl[i];
                lvl[i] = 1'b0;
            end else if (m != m_mprev && lvl[i]) begin
                dex[i] = 1'b1;
                lvl[i] = 1'b0;
            end else begin
                case (m)
                    2'b00, 2'b01: begin
                        if (!lvl[i]) begin
                            if (ev) begin
                                lvl[i] = 1'b1;
                                expt[i] = t + hc[i];
                            end
                        end else if (m == 2'b01 && ev) begin
                            expt[i] = t + hc[i];
                        end else if (t == expt[i]) begin
                            lvl[i] = 1'b0;
                            dex[i] = 1'b1;
                        end
                    end
                    2'b10: if (ev) begin
                        dex[i] = lvl[i];
                        lvl[i] = ~lvl[i];
                    end
                    default: if (ev) lvl[i] = 1'b1;
                endcase
            end
        end
        m_pprev = p;
        m_mprev = m;
    endtask

    task automatic check_outs();
        chk("L8", int'(L8), int'(lvl[0]));
        chk("done8", int'(d8), int'(dex[0]));
        chk("L1", int'(L1), int'(lvl[1]));
        chk("done1", int'(d1), int'(dex[1]));
        chk("excl8", int'(L8 & d8), 0);
        chk("excl1", int'(L1 & d1), 0);
    endtask

    // called after a falling edge: drive, clock, model, sample at next falling edge
    task automatic step(input bit p, input bit [1:0] m, input bit c);
        P = p; mode = m; clr = c;
        @(posedge clk);
        model_edge(p, m, c);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n, input bit [1:0] m);
        for (int i = 0; i < n; i++) step(1'b0, m, 1'b0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_L8", int'(L8), 0);
        chk("rst_done8", int'(d8), 0);
        chk("rst_L1", int'(L1), 0);
        chk("rst_done1", int'(d1), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int hw;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_L", int'(L8), 0);
        chk("reset_done", int'(d8), 0);
        rst_n = 1'b1;

        // P held high across release is not an event
        for (int i = 0; i < 10; i++) step(1'b1, MODE_HOLD, 1'b0);
        idle(2, MODE_HOLD);
        step(1'b1, MODE_HOLD, 1'b0);
        chk("first_ev_L", int'(L8), 1);
        idle(10, MODE_HOLD);

        // HOLD with an ignored second pulse; width measured directly
        step(1'b1, MODE_HOLD, 1'b0);
        hw = 1;
        idle(2, MODE_HOLD);
        hw += 2;
        step(1'b1, MODE_HOLD, 1'b0);
        hw++;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, MODE_HOLD, 1'b0);
            if (L8) hw++;
        end
        chk("hold_width", hw, 8);

        // RETRIG: pulse, retrigger after 5, then a pulse exactly on the expiry edge
        step(1'b1, MODE_RETRIG, 1'b0);
        idle(4, MODE_RETRIG);
        step(1'b1, MODE_RETRIG, 1'b0);
        idle(7, MODE_RETRIG);
        step(1'b1, MODE_RETRIG, 1'b0);
        chk("retrig_expiry_L", int'(L8), 1);
        chk("retrig_expiry_done", int'(d8), 0);
        idle(12, MODE_RETRIG);

        // TOGGLE, including P held high for many cycles
        step(1'b1, MODE_TOGGLE, 1'b0);
        idle(3, MODE_TOGGLE);
        step(1'b1, MODE_TOGGLE, 1'b0);
        chk("toggle_off_done", int'(d8), 1);
        idle(2, MODE_TOGGLE);
        for (int i = 0; i < 11; i++) step(1'b1, MODE_TOGGLE, 1'b0);
        chk("toggle_held_L", int'(L8), 1);
        step(1'b0, MODE_TOGGLE, 1'b1);
        idle(2, MODE_TOGGLE);

        // LATCH: set, clear, then clear racing a pulse
        step(1'b1, MODE_LATCH, 1'b0);
        idle(5, MODE_LATCH);
        step(1'b0, MODE_LATCH, 1'b1);
        chk("latch_clr_done", int'(d8), 1);
        idle(2, MODE_LATCH);
        step(1'b1, MODE_LATCH, 1'b1);
        chk("latch_race_L", int'(L8), 0);
        idle(2, MODE_LATCH);

        // mode switch while active aborts
        step(1'b1, MODE_HOLD, 1'b0);
        idle(2, MODE_HOLD);
        step(1'b1, MODE_TOGGLE, 1'b0);
        chk("switch_L", int'(L8), 0);
        chk("switch_done", int'(d8), 1);
        idle(3, MODE_TOGGLE);

        // async reset mid-hold
        step(1'b1, MODE_HOLD, 1'b0);
        idle(3, MODE_HOLD);
        async_reset();
        idle(12, MODE_HOLD);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) < 4) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 99) < 35), mode, ($urandom_range(0, 99) < 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_to_level.md
# pulse_to_level

Pulse-to-level converter: turns single-cycle (or filtered button) events on `P` into a sustained level on `L`, the inverse of the team's level-to-pulse filter. Four modes: fixed-width one-shot, retriggerable one-shot, toggle, and set/clear latch. Sits between the debounced-button/edge-pulse logic and consumers that need a held enable (LED hold, timed outputs, on/off switches).

## Interface
- `HOLD_CYCLES`, default 8: high time of `L` in one-shot modes, in clock cycles; legal range ≥1.
- `CW`, default `$clog2(HOLD_CYCLES+1)`: hold-counter width; derived, not overridden.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `P`  in  1  event input; an event is a rising edge of `P` (P=1 now, 0 at previous edge).
- `mode`  in  2  00 HOLD, 01 RETRIG, 10 TOGGLE, 11 LATCH.
- `clr`  in  1  synchronous clear of `L`, all modes.
- `L`  out  1  registered output level.
- `done`  out  1  registered one-cycle pulse, high in the first cycle `L` is 0 after being 1.

## Operation
- Internal regs: `p_q` (previous P), `mode_q` (previous mode), `state` {IDLE, ACTIVE}, `cnt[CW-1:0]`.
- `ev = P & ~p_q`. `L` is 1 exactly when `state==ACTIVE`.
- Priority per edge: reset > clr > mode change > mode action.
- clr=1: state→IDLE, cnt→0; done=1 iff state was ACTIVE.
- `mode != mode_q` while ACTIVE: abort to IDLE, done=1; event on that edge ignored. While IDLE: no effect, new mode acts on the same edge.
- HOLD: IDLE+ev → ACTIVE, cnt←HOLD_CYCLES-1. ACTIVE: cnt≠0 → cnt−1; cnt==0 → IDLE, done=1. Events while ACTIVE ignored (including on the expiry edge).
- RETRIG: as HOLD, but ev while ACTIVE reloads cnt←HOLD_CYCLES-1 and stays ACTIVE; ev on the expiry edge reloads, no done.
- TOGGLE: ev flips state; ACTIVE→IDLE gives done=1. cnt held at 0.
- LATCH: ev sets ACTIVE; only clr (or mode change) leaves ACTIVE. Simultaneous clr and ev: clr wins, L=0.
- done=0 on every edge not listed above.

## Timing
- Reset (async assert, sync-to-clock release): L=0, done=0, state=IDLE, cnt=0, p_q=1, mode_q=00. p_q=1 ⇒ P held high across reset release is not an event; P must be seen low first.
- Latency: `P` sampled 1 at edge k with p_q=0 ⇒ L=1 from edge k (visible after k).
- HOLD/RETRIG: without retrigger, L high exactly HOLD_CYCLES clock periods; falls at edge k+HOLD_CYCLES, done high for that single cycle.
- HOLD_CYCLES=1: L high one cycle; in RETRIG, a new rising edge of P can only occur 2 cycles later, so L shows a 1-cycle gap.
- P held high continuously: exactly one event.
- `done` and `L` never both 1.

## Structure
- Shared package/header: mode encodings MODE_HOLD/RETRIG/TOGGLE/LATCH, state encoding ST_IDLE/ST_ACTIVE.
- One sub-module natural: `rise_detect` (registers p_q with reset value 1, outputs `ev`); counter and FSM stay in top.
- Target 120–200 lines RTL.

## Test plan
- Reset with P=1 held, release, keep P=1 10 cycles → L=0, done=0 throughout; drop P, pulse P 1 cycle → L=1 next edge.
- HOLD, HOLD_CYCLES=8: pulse at edge 10, second pulse at edge 13 → L=1 edges 10–17, L=0 and done=1 at edge 18 only.
- RETRIG, HOLD_CYCLES=8: pulses at edges 10 and 15 → L=1 through edge 22, done=1 at edge 23; pulse exactly at expiry edge → no done, L stays 1.
- TOGGLE: pulses at edges 5, 9, 12 → L=1 at 5–8, done=1 at 9, L=1 from 12; P held high edges 20–30 → one toggle only.
- LATCH: pulse at 4, clr at 10 → L=1 edges 4–9, done=1 at 10; clr and pulse same edge → L stays 0.
- Mode switch HOLD→TOGGLE while ACTIVE at edge 6 → L=0, done=1 at 6; async rst_n low mid-hold → L=0, done=0 immediately, no done after release.
